// File: rtl/alu_pkg.sv
// Shared ALU encodings for the decode/execute boundary.
// The alu_op and funct3 constants are the instruction-side view; alu_ctrl_e is what the ALU consumes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_ILL = 4'hF
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    AOP_MEM = 2'b00,
    AOP_BR  = 2'b01,
    AOP_R   = 2'b10,
    AOP_I   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from alu_op/funct3/funct7[5].
// Anything without a defined code maps to ALU_ILL and raises illegal.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl    = ALU_ILL;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      AOP_MEM: ctrl = ALU_ADD;
      AOP_BR:  ctrl = ALU_SUB;
      default: begin
        // funct7[5] only selects SUB for register-register ops; immediates always add.
        case (funct3)
          F3_ADD:  ctrl = (alu_op_e'(alu_op) == AOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND:  ctrl = ALU_AND;
          F3_OR:   ctrl = ALU_OR;
          F3_SLT:  ctrl = ALU_SLT;
          default: begin
            ctrl    = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign alu_ctrl = ctrl;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards, decodes and captures one instruction's ALU operands.
// Single-entry valid/ready slot with stall and flush; out_ready only reaches in_ready combinationally.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              alu_src,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_we,
  input  logic              memwb_we,
  input  logic [XLEN-1:0]   exmem_res,
  input  logic [XLEN-1:0]   memwb_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] rd_q,
  output logic              reg_write_q,
  output logic              illegal
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [XLEN-1:0]   store_data_q, store_data_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [REG_AW-1:0] rd_d;
  logic              reg_write_d;
  logic              illegal_q, illegal_d;

  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
  logic [3:0]        dec_ctrl;
  logic              dec_illegal;
  logic              fire;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign fire     = in_valid && in_ready && !flush;

  // The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data;
    if (exmem_we && exmem_rd == rs1_addr && rs1_addr != '0)      fwd_rs1 = exmem_res;
    else if (memwb_we && memwb_rd == rs1_addr && rs1_addr != '0) fwd_rs1 = memwb_res;
    fwd_rs2 = rs2_data;
    if (exmem_we && exmem_rd == rs2_addr && rs2_addr != '0)      fwd_rs2 = exmem_res;
    else if (memwb_we && memwb_rd == rs2_addr && rs2_addr != '0) fwd_rs2 = memwb_res;
  end

  always_comb begin
    valid_d      = valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    store_data_d = store_data_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    illegal_d    = illegal_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (fire) begin
      valid_d      = 1'b1;
      alu_a_d      = fwd_rs1;
      alu_b_d      = alu_src ? imm : fwd_rs2;
      store_data_d = fwd_rs2;
      alu_ctrl_d   = dec_ctrl;
      rd_d         = rd_addr;
      reg_write_d  = reg_write && !dec_illegal;
      illegal_d    = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      store_data_q <= '0;
      alu_ctrl_q   <= ALU_AND;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      store_data_q <= store_data_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign store_data = store_data_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of decode/forwarding vectors checked through a scoreboard queue,
// plus hand-written stall, flush and asynchronous-reset sequences.
module tb_id_ex_stage;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        rw;
    logic [4:0]  exrd, wbrd;
    logic        exwe, wbwe;
    logic [31:0] exres, wbres;
    logic [31:0] ea, eb, es;
    logic [3:0]  ec;
    logic        eill, erw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, alu_src, reg_write, exmem_we, memwb_we;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, rd_q;
  logic [31:0] rs1_data, rs2_data, imm, exmem_res, memwb_res;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_ctrl;
  logic        reg_write_q, illegal;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[15];
  vec_t expQ[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .rd_addr(rd_addr), .reg_write(reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .exmem_res(exmem_res), .memwb_res(memwb_res),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .store_data(store_data), .rd_q(rd_q),
    .reg_write_q(reg_write_q), .illegal(illegal)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                 input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                                 input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es,
                                 input logic [3:0] ec, input logic eill, input logic erw);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.src = src;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = 5'd9;
    v.d1 = d1; v.d2 = d2; v.imm = im; v.rw = 1'b1;
    v.exrd = 5'd0; v.wbrd = 5'd0; v.exwe = 1'b0; v.wbwe = 1'b0;
    v.exres = 32'h0; v.wbres = 32'h0;
    v.ea = ea; v.eb = eb; v.es = es; v.ec = ec; v.eill = eill; v.erw = erw;
    return v;
  endfunction

  task automatic setEntry(input vec_t v);
    alu_op = v.op; funct3 = v.f3; funct7_5 = v.f7; alu_src = v.src;
    rs1_addr = v.rs1; rs2_addr = v.rs2; rs1_data = v.d1; rs2_data = v.d2;
    imm = v.imm; rd_addr = v.rd; reg_write = v.rw;
    exmem_rd = v.exrd; exmem_we = v.exwe; exmem_res = v.exres;
    memwb_rd = v.wbrd; memwb_we = v.wbwe; memwb_res = v.wbres;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    setEntry(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    int   waited = 0;
    while (!out_valid && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!out_valid || expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL vec%0d no output: out_valid=%0b queued=%0d", idx, out_valid, expQ.size());
      if (expQ.size() != 0) void'(expQ.pop_front());
    end else begin
      e = expQ.pop_front();
      checkVal($sformatf("vec%0d alu_a", idx), alu_a, e.ea);
      checkVal($sformatf("vec%0d alu_b", idx), alu_b, e.eb);
      checkVal($sformatf("vec%0d store_data", idx), store_data, e.es);
      checkVal($sformatf("vec%0d alu_ctrl", idx), {28'h0, alu_ctrl}, {28'h0, e.ec});
      checkVal($sformatf("vec%0d illegal", idx), {31'h0, illegal}, {31'h0, e.eill});
      checkVal($sformatf("vec%0d reg_write_q", idx), {31'h0, reg_write_q}, {31'h0, e.erw});
      checkVal($sformatf("vec%0d rd_q", idx), {27'h0, rd_q}, {27'h0, e.rd});
    end
  endtask

  initial begin
    // Hard stop in case a sequence deadlocks; still reports through the summary line.
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vecs[0]  = mkVec(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h100, 32'd5, 32'd7, 32'd7, 4'h2, 1'b0, 1'b1);
    vecs[1]  = mkVec(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 32'd20, 32'd3, 32'h0, 32'd20, 32'd3, 32'd3, 4'h6, 1'b0, 1'b1);
    vecs[2]  = mkVec(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 32'hF0, 32'h3C, 32'h0, 32'hF0, 32'h3C, 32'h3C, 4'h0, 1'b0, 1'b1);
    vecs[3]  = mkVec(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd2, 32'hF0, 32'h3C, 32'h0, 32'hF0, 32'h3C, 32'h3C, 4'h1, 1'b0, 1'b1);
    vecs[4]  = mkVec(2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h1, 32'h2, 32'h2, 4'h7, 1'b0, 1'b1);
    vecs[5]  = mkVec(2'b11, 3'b000, 1'b1, 1'b1, 5'd4, 5'd6, 32'h11, 32'h22, 32'h10, 32'h11, 32'h10, 32'h22, 4'h2, 1'b0, 1'b1);
    vecs[6]  = mkVec(2'b00, 3'b010, 1'b0, 1'b1, 5'd8, 5'd9, 32'h1000, 32'h55, 32'hFFFFFFFC, 32'h1000, 32'hFFFFFFFC, 32'h55, 4'h2, 1'b0, 1'b1);
    vecs[7]  = mkVec(2'b01, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 32'd9, 32'd9, 32'h0, 32'd9, 32'd9, 32'd9, 4'h6, 1'b0, 1'b1);
    vecs[8]  = mkVec(2'b10, 3'b001, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'd5, 32'd7, 32'd7, 4'hF, 1'b1, 1'b0);
    vecs[9]  = mkVec(2'b11, 3'b101, 1'b0, 1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 32'h20, 32'd5, 32'h20, 32'd7, 4'hF, 1'b1, 1'b0);
    vecs[10] = mkVec(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 32'h11, 32'h22, 32'h0, 32'hAA, 32'h22, 32'h22, 4'h2, 1'b0, 1'b1);
    vecs[10].exrd = 5'd3; vecs[10].exwe = 1'b1; vecs[10].exres = 32'hAA;
    vecs[10].wbrd = 5'd3; vecs[10].wbwe = 1'b1; vecs[10].wbres = 32'hBB;
    vecs[11] = vecs[10];
    vecs[11].exwe = 1'b0; vecs[11].ea = 32'hBB;
    vecs[12] = mkVec(2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 5'd4, 32'h11, 32'h22, 32'h0, 32'h11, 32'h22, 32'h22, 4'h2, 1'b0, 1'b1);
    vecs[12].exrd = 5'd0; vecs[12].exwe = 1'b1; vecs[12].exres = 32'hAA;
    vecs[12].wbrd = 5'd0; vecs[12].wbwe = 1'b1; vecs[12].wbres = 32'hBB;
    vecs[13] = mkVec(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd4, 32'h1, 32'h22, 32'h0, 32'h1, 32'hCC, 32'hCC, 4'h2, 1'b0, 1'b1);
    vecs[13].wbrd = 5'd4; vecs[13].wbwe = 1'b1; vecs[13].wbres = 32'hCC;
    vecs[13].exrd = 5'd5; vecs[13].exwe = 1'b1; vecs[13].exres = 32'hDD;
    vecs[14] = mkVec(2'b11, 3'b111, 1'b0, 1'b1, 5'd1, 5'd4, 32'hFF, 32'h22, 32'h0F, 32'hFF, 32'h0F, 32'hDD, 4'h0, 1'b0, 1'b1);
    vecs[14].exrd = 5'd4; vecs[14].exwe = 1'b1; vecs[14].exres = 32'hDD;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    setEntry(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkVal("reset alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
    checkVal("reset illegal", {31'h0, illegal}, 32'h0);
    checkVal("reset reg_write_q", {31'h0, reg_write_q}, 32'h0);
    checkVal("reset in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 15; i++) begin
      vecs[i].rd = 5'(i + 1);
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Stall: entry A held while B waits, then B captured once out_ready returns.
    @(negedge clk);
    setEntry(vecs[0]); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0; setEntry(vecs[1]); in_valid = 1'b1;
    #1;
    checkVal("stall in_ready", {31'h0, in_ready}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checkVal($sformatf("stall%0d out_valid", c), {31'h0, out_valid}, 32'h1);
      checkVal($sformatf("stall%0d alu_a", c), alu_a, 32'd5);
      checkVal($sformatf("stall%0d alu_ctrl", c), {28'h0, alu_ctrl}, 32'h2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkVal("unstall in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    checkVal("unstall alu_a", alu_a, 32'd20);
    checkVal("unstall alu_ctrl", {28'h0, alu_ctrl}, 32'h6);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkVal("drain out_valid", {31'h0, out_valid}, 32'h0);
    checkVal("drain alu_a hold", alu_a, 32'd20);

    // Flush kills a same-cycle capture; the next entry goes through normally.
    @(negedge clk);
    setEntry(vecs[0]); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checkVal("flush out_valid", {31'h0, out_valid}, 32'h0);
    checkVal("flush reg_write_q", {31'h0, reg_write_q}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    checkVal("postflush out_valid", {31'h0, out_valid}, 32'h1);
    checkVal("postflush alu_a", alu_a, 32'd5);
    checkVal("postflush reg_write_q", {31'h0, reg_write_q}, 32'h1);

    // Asynchronous reset between edges while stalled.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    checkVal("prereset out_valid", {31'h0, out_valid}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkVal("async rst out_valid", {31'h0, out_valid}, 32'h0);
    checkVal("async rst alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
    checkVal("async rst alu_a", alu_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("post rst in_ready", {31'h0, in_ready}, 32'h1);
    checkVal("post rst out_valid", {31'h0, out_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
